// File: rtl/cp0_ctrl_if.sv
// cp0_ctrl_if: commit-stage <-> CP0 signal bundle (mtc0/mfc0, exception flags, redirect, register taps)
interface cp0_ctrl_if #(parameter int NUM_HW_INT = 6);
    logic                  w_en_i;
    logic [4:0]            w_addr_i;
    logic [31:0]           data_i;
    logic [4:0]            r_addr_i;
    logic [31:0]           data_o;
    logic [NUM_HW_INT-1:0] hw_int_i;
    logic                  commit_valid_i;
    logic [7:0]            exc_i;
    logic [31:0]           badvaddr_i;
    logic [31:0]           current_inst_addr_i;
    logic                  is_in_delay_slot;
    logic                  exc_taken_o;
    logic [31:0]           exc_pc_o;
    logic [31:0]           status_o;
    logic [31:0]           cause_o;
    logic [31:0]           epc_o;
    logic                  time_int_o;
    modport master (
        output w_en_i, w_addr_i, data_i, r_addr_i, hw_int_i, commit_valid_i, exc_i,
               badvaddr_i, current_inst_addr_i, is_in_delay_slot,
        input  data_o, exc_taken_o, exc_pc_o, status_o, cause_o, epc_o, time_int_o
    );
    modport slave (
        input  w_en_i, w_addr_i, data_i, r_addr_i, hw_int_i, commit_valid_i, exc_i,
               badvaddr_i, current_inst_addr_i, is_in_delay_slot,
        output data_o, exc_taken_o, exc_pc_o, status_o, cause_o, epc_o, time_int_o
    );
endinterface

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: system coprocessor holding BadVAddr/Count/Compare/Status/Cause/EPC/PRId, with prioritised trap redirect
module cp0_ctrl #(
    parameter int          NUM_HW_INT   = 6,
    parameter int          COUNT_DIV    = 1,
    parameter logic [31:0] STATUS_RESET = 32'h1000ff01,
    parameter logic [31:0] STATUS_WMASK = 32'h1000ff03,
    parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380,
    parameter logic [31:0] PRID         = 32'h00018000
) (
    input logic      clk,
    input logic      reset_n,
    cp0_ctrl_if.slave bus
);
    logic [31:0]           badvaddr_q, badvaddr_d, count_q, count_d, compare_q, compare_d;
    logic [31:0]           status_q, status_d, epc_q, epc_d, cause;
    logic [NUM_HW_INT-1:0] ip_hw_q;
    logic [1:0]            ip_sw_q, ip_sw_d;
    logic                  bd_q, bd_d, ti_q, ti_d;
    logic [4:0]            exccode_q, exccode_d, code;
    logic [3:0]            presc_q, presc_d;
    logic [7:0]            ip, ex;
    logic                  irq, exc, eret, taken, wr, wr_count, wr_cmp, wrap, first;
    always_comb begin
        ip        = 8'({ip_hw_q, ip_sw_q}) | {ti_q, 7'b0};
        cause     = {bd_q, ti_q, 14'b0, ip, 1'b0, exccode_q, 2'b0};
        ex        = bus.commit_valid_i ? bus.exc_i : 8'h0;
        irq       = bus.commit_valid_i & status_q[0] & ~status_q[1] & |(ip & status_q[15:8]);
        exc       = irq | |ex[6:0];
        eret      = ~exc & ex[7];
        taken     = exc | eret;
        first     = exc & ~status_q[1];
        code      = irq   ? 5'd0  : ex[0] ? 5'd4 : ex[1] ? 5'd10 : ex[2] ? 5'd12 :
                    ex[3] ? 5'd8  : ex[4] ? 5'd9 : ex[5] ? 5'd4  : 5'd5;
        // a trap or eret in the same cycle squashes the mtc0
        wr        = bus.w_en_i & ~taken;
        wr_count  = wr && bus.w_addr_i == 5'd9;
        wr_cmp    = wr && bus.w_addr_i == 5'd11;
        wrap      = presc_q == 4'(COUNT_DIV - 1);
        presc_d   = (wr_count | wrap) ? 4'd0 : presc_q + 4'd1;
        count_d   = wr_count ? bus.data_i : count_q + {31'b0, wrap};
        compare_d = wr_cmp ? bus.data_i : compare_q;
        ti_d      = ~wr_cmp & (ti_q | (count_d == compare_q && compare_q != 32'd0));
        status_d  = exc  ? status_q | 32'h2 :
                    eret ? status_q & ~32'h2 :
                    (wr && bus.w_addr_i == 5'd12) ? (status_q & ~STATUS_WMASK) | (bus.data_i & STATUS_WMASK) :
                    status_q;
        epc_d     = first ? bus.current_inst_addr_i - (bus.is_in_delay_slot ? 32'd4 : 32'd0) :
                    (wr && bus.w_addr_i == 5'd14) ? bus.data_i : epc_q;
        bd_d      = first ? bus.is_in_delay_slot : bd_q;
        exccode_d = exc ? code : exccode_q;
        ip_sw_d   = (wr && bus.w_addr_i == 5'd13) ? bus.data_i[9:8] : ip_sw_q;
        badvaddr_d = (exc & ~irq & ex[0]) ? bus.current_inst_addr_i :
                     (exc & ~irq & ~|ex[4:0] & |ex[6:5]) ? bus.badvaddr_i : badvaddr_q;
        case (bus.r_addr_i)
            5'd8:    bus.data_o = badvaddr_q;
            5'd9:    bus.data_o = count_q;
            5'd11:   bus.data_o = compare_q;
            5'd12:   bus.data_o = status_q;
            5'd13:   bus.data_o = cause;
            5'd14:   bus.data_o = epc_q;
            5'd15:   bus.data_o = PRID;
            default: bus.data_o = 32'd0;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            badvaddr_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            status_q   <= STATUS_RESET;
            epc_q      <= '0;
            ip_hw_q    <= '0;
            ip_sw_q    <= '0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            exccode_q  <= '0;
            presc_q    <= '0;
        end else begin
            badvaddr_q <= badvaddr_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            status_q   <= status_d;
            epc_q      <= epc_d;
            ip_hw_q    <= bus.hw_int_i;
            ip_sw_q    <= ip_sw_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            exccode_q  <= exccode_d;
            presc_q    <= presc_d;
        end
    assign bus.exc_taken_o = taken;
    assign bus.exc_pc_o    = eret ? epc_q : EXC_VECTOR;
    assign bus.status_o    = status_q;
    assign bus.cause_o     = cause;
    assign bus.epc_o       = epc_q;
    assign bus.time_int_o  = ti_q;
endmodule
